// File: rtl/mlp_infer_seq.sv
// Inference sequencer for a 784-32-10 int8 MLP: two parallel MAC layers with bias, ReLU and
// requantisation, then an argmax over the output logits.
module mlp_infer_seq #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10,
  parameter int ACC_W = 32,
  parameter int SHIFT = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              layer_sel,
  output logic [9:0]              row_idx,
  output logic [9:0]              px_addr,
  input  logic signed [7:0]       px_data,
  input  logic [N_HID*8-1:0]      w1_in,
  input  logic [N_HID*8-1:0]      b1_in,
  input  logic [N_OUT*8-1:0]      w2_in,
  input  logic [N_OUT*8-1:0]      b2_in,
  output logic [3:0]              pred,
  output logic signed [ACC_W-1:0] max_score
);

  localparam int HID_W = $clog2(N_HID);
  localparam int OUT_W = $clog2(N_OUT);

  typedef enum logic [2:0] {IDLE, L1_MAC, L1_ACT, L2_MAC, L2_ACT, ARGMAX, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [9:0]              cnt_reg;
  logic [9:0]              row_idx_reg;
  logic [9:0]              px_addr_reg;
  logic signed [ACC_W-1:0] best_reg;
  logic [3:0]              best_idx_reg;
  logic [3:0]              pred_reg;
  logic signed [ACC_W-1:0] max_score_reg;

  logic [N_HID-1:0][7:0]       h_vec;
  logic [N_OUT-1:0][ACC_W-1:0] logit_vec;
  logic [7:0]                  h_sel;
  logic signed [ACC_W-1:0]     scan_val;
  logic                        take_it;
  logic signed [ACC_W-1:0]     new_best;
  logic [3:0]                  new_idx;
  logic                        acc_clr;
  logic                        l1_mac_en;

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    done       = (state_reg == DONE);
    layer_sel  = 2'd0;
    unique case (state_reg)
      IDLE:   if (start) state_next = L1_MAC;
      L1_MAC: begin
        layer_sel = 2'd1;
        if (cnt_reg == 10'(N_IN)) state_next = L1_ACT;
      end
      L1_ACT: begin
        layer_sel  = 2'd1;
        state_next = L2_MAC;
      end
      L2_MAC: begin
        layer_sel = 2'd2;
        if (cnt_reg == 10'(N_HID - 1)) state_next = L2_ACT;
      end
      L2_ACT: begin
        layer_sel  = 2'd2;
        state_next = ARGMAX;
      end
      ARGMAX: if (cnt_reg == 10'(N_OUT - 1)) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign acc_clr   = (state_reg == IDLE) && start;
  // Pixel data lags its address by one cycle, so the first L1 cycle has nothing to accumulate.
  assign l1_mac_en = (state_reg == L1_MAC) && (cnt_reg != 10'd0);

  assign h_sel    = h_vec[row_idx_reg[HID_W-1:0]];
  assign scan_val = logit_vec[cnt_reg[OUT_W-1:0]];
  assign take_it  = (cnt_reg == 10'd0) || (scan_val > best_reg);
  assign new_best = take_it ? scan_val : best_reg;
  assign new_idx  = take_it ? 4'(cnt_reg[OUT_W-1:0]) : best_idx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      row_idx_reg   <= '0;
      px_addr_reg   <= '0;
      best_reg      <= '0;
      best_idx_reg  <= '0;
      pred_reg      <= '0;
      max_score_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= (state_next != state_reg) ? 10'd0 : cnt_reg + 10'd1;
      unique case (state_reg)
        IDLE: begin
          cnt_reg     <= '0;
          row_idx_reg <= '0;
          px_addr_reg <= '0;
        end
        L1_MAC: begin
          row_idx_reg <= px_addr_reg;
          if (cnt_reg < 10'(N_IN - 1)) px_addr_reg <= cnt_reg + 10'd1;
        end
        L1_ACT: row_idx_reg <= '0;
        L2_MAC: if (cnt_reg < 10'(N_HID - 1)) row_idx_reg <= cnt_reg + 10'd1;
        L2_ACT: ;
        ARGMAX: begin
          best_reg     <= new_best;
          best_idx_reg <= new_idx;
          // Publish on the last scan step so pred is already valid during DONE.
          if (cnt_reg == 10'(N_OUT - 1)) begin
            pred_reg      <= new_idx;
            max_score_reg <= new_best;
          end
        end
        DONE: begin
          row_idx_reg <= '0;
          px_addr_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_HID; gi++) begin : g_l1
      logic signed [15:0]      prod;
      logic signed [ACC_W-1:0] acc_reg;
      logic signed [ACC_W-1:0] biased;
      logic signed [ACC_W-1:0] t;
      logic [7:0]              h_reg;

      assign prod   = px_data * $signed(w1_in[gi*8 +: 8]);
      assign biased = acc_reg + (ACC_W'($signed(b1_in[gi*8 +: 8])) <<< SHIFT);
      assign t      = biased >>> SHIFT;

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
          h_reg   <= '0;
        end else if (acc_clr) begin
          acc_reg <= '0;
        end else if (l1_mac_en) begin
          acc_reg <= acc_reg + ACC_W'(prod);
        end else if (state_reg == L1_ACT) begin
          h_reg <= (t < 0) ? 8'd0 : (t > 127) ? 8'd127 : t[7:0];
        end
      end

      assign h_vec[gi] = h_reg;
    end

    for (gi = 0; gi < N_OUT; gi++) begin : g_l2
      logic signed [15:0]      prod;
      logic signed [ACC_W-1:0] acc_reg;

      // h is clamped to 0..127, so reading it as signed is lossless.
      assign prod = $signed(h_sel) * $signed(w2_in[gi*8 +: 8]);

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_reg <= '0;
        end else if (acc_clr) begin
          acc_reg <= '0;
        end else if (state_reg == L2_MAC) begin
          acc_reg <= acc_reg + ACC_W'(prod);
        end else if (state_reg == L2_ACT) begin
          acc_reg <= acc_reg + ACC_W'($signed(b2_in[gi*8 +: 8]));
        end
      end

      assign logit_vec[gi] = acc_reg;
    end
  endgenerate

  assign row_idx   = row_idx_reg;
  assign px_addr   = px_addr_reg;
  assign pred      = pred_reg;
  assign max_score = max_score_reg;

endmodule

// File: tb/tb_mlp_infer_seq.sv
// Directed bench for mlp_infer_seq: uniform-weight vectors with hand-computed argmax results,
// latency, ignored starts and mid-run reset.
module tb_mlp_infer_seq;
  localparam int N_IN  = 784;
  localparam int N_HID = 32;
  localparam int N_OUT = 10;
  localparam int ACC_W = 32;
  localparam int LAT   = 829;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic [1:0] layer_sel;
  logic [9:0] row_idx;
  logic [9:0] px_addr;
  logic signed [7:0] px_data;
  logic [N_HID*8-1:0] w1_in;
  logic [N_HID*8-1:0] b1_in;
  logic [N_OUT*8-1:0] w2_in;
  logic [N_OUT*8-1:0] b2_in;
  logic [3:0] pred;
  logic signed [ACC_W-1:0] max_score;

  logic signed [7:0] px_mem [1024];
  logic signed [7:0] w1_val;
  logic signed [7:0] b1_val;
  logic signed [7:0] w2_lane [N_OUT];
  logic signed [7:0] b2_lane [N_OUT];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) px_data <= px_mem[px_addr];

  always_comb begin
    w1_in = '0;
    b1_in = '0;
    w2_in = '0;
    b2_in = '0;
    for (int k = 0; k < N_HID; k++) begin
      w1_in[k*8 +: 8] = w1_val;
      b1_in[k*8 +: 8] = b1_val;
    end
    for (int m = 0; m < N_OUT; m++) begin
      w2_in[m*8 +: 8] = w2_lane[m];
      b2_in[m*8 +: 8] = b2_lane[m];
    end
  end

  mlp_infer_seq dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .layer_sel(layer_sel), .row_idx(row_idx), .px_addr(px_addr), .px_data(px_data),
    .w1_in(w1_in), .b1_in(b1_in), .w2_in(w2_in), .b2_in(b2_in),
    .pred(pred), .max_score(max_score)
  );

  // Pixels beyond the image hold a poison value so an address overrun skews the result.
  task automatic config_net(input logic signed [7:0] px, input logic signed [7:0] w1,
                            input logic signed [7:0] b1);
    for (int i = 0; i < 1024; i++) px_mem[i] = (i < N_IN) ? px : 8'sd100;
    w1_val = w1;
    b1_val = b1;
    for (int m = 0; m < N_OUT; m++) begin
      w2_lane[m] = 8'sd0;
      b2_lane[m] = 8'sd0;
    end
  endtask

  task automatic run_inf(input bit extra_starts, output int lat, output int n_done,
                         output bit busy_drop, output logic [9:0] px_at10,
                         output logic [1:0] sel_at800, output logic [9:0] row_at800);
    lat = 0;
    n_done = 0;
    busy_drop = 0;
    px_at10 = '0;
    sel_at800 = '0;
    row_at800 = '0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      start = extra_starts && (lat == 10 || lat == 500);
      if (lat == 10) px_at10 = px_addr;
      if (lat == 800) begin
        sel_at800 = layer_sel;
        row_at800 = row_idx;
      end
      if (done) begin
        n_done++;
        break;
      end
      if (!busy) busy_drop = 1'b1;
    end
    start = 1'b0;
    $display("run: latency=%0d pred=%0d max_score=%0d", lat, pred, max_score);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    config_net(8'sd0, 8'sd0, 8'sd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else passed++;
    total++; if (layer_sel !== 2'd0) $display("FAIL reset_layer_sel: got %0d expected 0", layer_sel); else passed++;
    total++; if (row_idx !== 10'd0) $display("FAIL reset_row_idx: got %0d expected 0", row_idx); else passed++;
    total++; if (px_addr !== 10'd0) $display("FAIL reset_px_addr: got %0d expected 0", px_addr); else passed++;
    total++; if (pred !== 4'd0) $display("FAIL reset_pred: got %0d expected 0", pred); else passed++;
    total++; if (max_score !== 32'sd0) $display("FAIL reset_max_score: got %0d expected 0", max_score); else passed++;
  endtask

  task automatic test_bias_only();
    int lat, n_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd0, 8'sd0, 8'sd0);
    b2_lane[3] = 8'sd5;
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (lat !== LAT) $display("FAIL t1_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (pred !== 4'd3) $display("FAIL t1_pred: got %0d expected 3", pred); else passed++;
    total++; if (max_score !== 32'sd5) $display("FAIL t1_max_score: got %0d expected 5", max_score); else passed++;
    total++; if (busy_drop !== 1'b0) $display("FAIL t1_busy_held: got drop=%0b expected 0", busy_drop); else passed++;
    total++; if (p10 !== 10'd10) $display("FAIL t1_px_addr_c10: got %0d expected 10", p10); else passed++;
    total++; if (s800 !== 2'd2) $display("FAIL t1_layer_sel_c800: got %0d expected 2", s800); else passed++;
    total++; if (r800 !== 10'd14) $display("FAIL t1_row_idx_c800: got %0d expected 14", r800); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL t1_done_pulse: got %0b expected 0", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL t1_busy_after: got %0b expected 0", busy); else passed++;
    total++; if (pred !== 4'd3) $display("FAIL t1_pred_hold: got %0d expected 3", pred); else passed++;
  endtask

  task automatic test_tie();
    int lat, n_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd0, 8'sd0, 8'sd0);
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (pred !== 4'd0) $display("FAIL t2_pred: got %0d expected 0", pred); else passed++;
    total++; if (max_score !== 32'sd0) $display("FAIL t2_max_score: got %0d expected 0", max_score); else passed++;
  endtask

  task automatic test_saturate();
    int lat, n_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd127, 8'sd127, 8'sd0);
    w2_lane[7] = 8'sd1;
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (pred !== 4'd7) $display("FAIL t3_pred: got %0d expected 7", pred); else passed++;
    total++; if (max_score !== 32'sd4064) $display("FAIL t3_max_score: got %0d expected 4064", max_score); else passed++;
  endtask

  task automatic test_relu();
    int lat, n_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd1, -8'sd1, 8'sd0);
    w2_lane[0] = 8'sd1;
    for (int m = 0; m < N_OUT; m++) b2_lane[m] = -8'sd2;
    b2_lane[9] = -8'sd1;
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (pred !== 4'd9) $display("FAIL t4_pred: got %0d expected 9", pred); else passed++;
    total++; if (max_score !== -32'sd1) $display("FAIL t4_max_score: got %0d expected -1", max_score); else passed++;
  endtask

  // h = (784 + (1<<7)) >>> 7 = 7; logit2 = 32*7*3 - 2 = 670.
  task automatic test_requant();
    int lat, n_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd1, 8'sd1, 8'sd1);
    w2_lane[2] = 8'sd3;
    b2_lane[2] = -8'sd2;
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (pred !== 4'd2) $display("FAIL requant_pred: got %0d expected 2", pred); else passed++;
    total++; if (max_score !== 32'sd670) $display("FAIL requant_max_score: got %0d expected 670", max_score); else passed++;
  endtask

  task automatic test_ignored_start();
    int lat, n_done, extra;
    bit busy_drop, busy_after;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd0, 8'sd0, 8'sd0);
    b2_lane[3] = 8'sd5;
    run_inf(1'b1, lat, n_done, busy_drop, p10, s800, r800);
    extra = 0;
    busy_after = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) extra++;
      if (busy) busy_after = 1'b1;
    end
    total++; if (lat !== LAT) $display("FAIL t5_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (n_done !== 1) $display("FAIL t5_done_count: got %0d expected 1", n_done); else passed++;
    total++; if (busy_drop !== 1'b0) $display("FAIL t5_busy_held: got drop=%0b expected 0", busy_drop); else passed++;
    total++; if (extra !== 0) $display("FAIL t5_extra_done: got %0d expected 0", extra); else passed++;
    total++; if (busy_after !== 1'b0) $display("FAIL t5_no_queue: got busy=%0b expected 0", busy_after); else passed++;
  endtask

  task automatic test_reset_abort();
    int lat, n_done, early_done;
    bit busy_drop;
    logic [9:0] p10, r800;
    logic [1:0] s800;
    config_net(8'sd0, 8'sd0, 8'sd0);
    b2_lane[3] = 8'sd5;
    early_done = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 1; c <= 790; c++) begin
      @(negedge clk);
      if (done) early_done++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL t6_busy: got %0b expected 0", busy); else passed++;
    total++; if (layer_sel !== 2'd0) $display("FAIL t6_layer_sel: got %0d expected 0", layer_sel); else passed++;
    total++; if (done !== 1'b0 || early_done !== 0) $display("FAIL t6_no_done: got done=%0b early=%0d expected 0", done, early_done); else passed++;
    total++; if (pred !== 4'd0) $display("FAIL t6_pred_cleared: got %0d expected 0", pred); else passed++;
    total++; if (max_score !== 32'sd0) $display("FAIL t6_score_cleared: got %0d expected 0", max_score); else passed++;
    run_inf(1'b0, lat, n_done, busy_drop, p10, s800, r800);
    total++; if (lat !== LAT) $display("FAIL t6_latency: got %0d expected %0d", lat, LAT); else passed++;
    total++; if (pred !== 4'd3) $display("FAIL t6_pred: got %0d expected 3", pred); else passed++;
    total++; if (max_score !== 32'sd5) $display("FAIL t6_max_score: got %0d expected 5", max_score); else passed++;
  endtask

  initial begin
    test_reset();
    test_bias_only();
    test_tie();
    test_saturate();
    test_relu();
    test_requant();
    test_ignored_start();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
